// File: rtl/shift_engine.sv
// Multi-mode shift engine: loads a word, then performs `count` single-bit
// logical/rotate/arithmetic shifts (one per cycle) with busy/done status.
module shift_engine #(
    parameter int WIDTH = 8,
    parameter int CW    = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             load,
    input  logic             abort,
    input  logic [WIDTH-1:0] data,
    input  logic [CW-1:0]    count,
    input  logic             dir,
    input  logic [1:0]       mode,
    input  logic             ser_in,
    output logic [WIDTH-1:0] q,
    output logic             ser_out,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [CW-1:0]    rem_q, rem_d;
    logic             dir_q, dir_d;
    logic [1:0]       mode_q, mode_d;
    logic             ser_out_q, ser_out_d;

    logic             fill;
    logic [WIDTH-1:0] shifted;

    always_comb begin
        fill = ser_in;
        case (mode_q)
            2'b01:   fill = dir_q ? q_q[0] : q_q[WIDTH-1];
            2'b10:   fill = dir_q ? q_q[WIDTH-1] : 1'b0;
            default: fill = ser_in;
        endcase
        shifted = dir_q ? {fill, q_q[WIDTH-1:1]} : {q_q[WIDTH-2:0], fill};
    end

    always_comb begin
        state_d   = state_q;
        q_d       = q_q;
        rem_d     = rem_q;
        dir_d     = dir_q;
        mode_d    = mode_q;
        ser_out_d = ser_out_q;

        if (abort) begin
            // Abort freezes q/ser_out and drops back without a done pulse.
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_SHIFT: begin
                    q_d       = shifted;
                    ser_out_d = dir_q ? q_q[0] : q_q[WIDTH-1];
                    rem_d     = rem_q - 1'b1;
                    if (rem_q == CW'(1)) begin
                        state_d = S_DONE;
                    end
                end
                default: begin
                    if (start) begin
                        q_d     = data;
                        rem_d   = count;
                        dir_d   = dir;
                        mode_d  = mode;
                        state_d = (count == '0) ? S_DONE : S_SHIFT;
                    end else if (load) begin
                        q_d     = data;
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            q_q       <= '0;
            rem_q     <= '0;
            dir_q     <= 1'b0;
            mode_q    <= 2'b00;
            ser_out_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            q_q       <= q_d;
            rem_q     <= rem_d;
            dir_q     <= dir_d;
            mode_q    <= mode_d;
            ser_out_q <= ser_out_d;
        end
    end

    assign q       = q_q;
    assign ser_out = ser_out_q;
    assign busy    = (state_q == S_SHIFT);
    assign done    = (state_q == S_DONE);

endmodule

// File: tb/tb_shift_engine.sv
// Self-checking bench for shift_engine: directed scenarios plus randomized
// traffic compared cycle-by-cycle against a behavioural model.
module tb_shift_engine;

    localparam int WIDTH = 8;
    localparam int CW    = $clog2(WIDTH) + 1;
    localparam int MASK  = (1 << WIDTH) - 1;

    logic             clk = 1'b0;
    logic             rst, start, load, abort, dir, ser_in;
    logic [WIDTH-1:0] data;
    logic [CW-1:0]    count;
    logic [1:0]       mode;
    logic [WIDTH-1:0] q;
    logic             ser_out, busy, done;

    int checks = 0;
    int errors = 0;

    // model: phase 0 idle, 1 shifting, 2 done
    int m_phase, m_q, m_rem, m_dir, m_mode, m_so;

    shift_engine #(.WIDTH(WIDTH), .CW(CW)) dut (
        .clk(clk), .rst(rst), .start(start), .load(load), .abort(abort),
        .data(data), .count(count), .dir(dir), .mode(mode), .ser_in(ser_in),
        .q(q), .ser_out(ser_out), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_edge();
        int fill, mode_eff;
        if (rst) begin
            m_phase = 0; m_q = 0; m_rem = 0; m_so = 0; m_dir = 0; m_mode = 0;
        end else if (abort) begin
            m_phase = 0;
        end else if (m_phase == 1) begin
            mode_eff = (m_mode == 3) ? 0 : m_mode;
            if (m_dir == 1) begin
                if (mode_eff == 0)      fill = ser_in;
                else if (mode_eff == 1) fill = m_q & 1;
                else                    fill = (m_q >> (WIDTH-1)) & 1;
                m_so = m_q & 1;
                m_q  = (m_q >> 1) | (fill << (WIDTH-1));
            end else begin
                if (mode_eff == 0)      fill = ser_in;
                else if (mode_eff == 1) fill = (m_q >> (WIDTH-1)) & 1;
                else                    fill = 0;
                m_so = (m_q >> (WIDTH-1)) & 1;
                m_q  = ((m_q << 1) & MASK) | fill;
            end
            m_rem = m_rem - 1;
            if (m_rem == 0) m_phase = 2;
        end else if (start) begin
            m_q = data; m_rem = count; m_dir = dir; m_mode = mode;
            m_phase = (count == 0) ? 2 : 1;
        end else if (load) begin
            m_q = data; m_phase = 0;
        end else begin
            m_phase = 0;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check("q", 32'(q), 32'(m_q));
        check("ser_out", 32'(ser_out), 32'(m_so));
        check("busy", 32'(busy), 32'(m_phase == 1));
        check("done", 32'(done), 32'(m_phase == 2));
    endtask

    task automatic idle_inputs();
        rst = 0; start = 0; load = 0; abort = 0;
    endtask

    task automatic go(input logic [WIDTH-1:0] d, input int c, input logic dr,
                      input logic [1:0] md, input logic si);
        idle_inputs();
        start = 1; data = d; count = CW'(c); dir = dr; mode = md; ser_in = si;
        tick();
        start = 0;
    endtask

    initial begin
        rst = 1; start = 0; load = 0; abort = 0; dir = 0; ser_in = 0;
        data = '0; count = '0; mode = 2'b00;
        tick();
        check("reset_q", 32'(q), 32'h0);
        check("reset_busy", 32'(busy), 32'h0);
        idle_inputs();
        tick();

        // reset mid-shift
        go(8'hA5, 5, 1'b0, 2'b00, 1'b1);
        tick();
        rst = 1;
        tick();
        check("rst_mid_q", 32'(q), 32'h0);
        check("rst_mid_busy", 32'(busy), 32'h0);
        check("rst_mid_done", 32'(done), 32'h0);
        check("rst_mid_so", 32'(ser_out), 32'h0);
        tick();
        rst = 0;
        tick();
        check("rst_no_done", 32'(done), 32'h0);

        // logical right B4, count 3, ser_in=1
        go(8'hB4, 3, 1'b1, 2'b00, 1'b1);
        check("lr_load", 32'(q), 32'hB4);
        check("lr_busy0", 32'(busy), 32'h1);
        tick(); check("lr_s1", 32'(q), 32'hDA);
        tick(); check("lr_s2", 32'(q), 32'hED);
        check("lr_busy2", 32'(busy), 32'h1);
        tick(); check("lr_s3", 32'(q), 32'hF6);
        check("lr_so", 32'(ser_out), 32'h1);
        check("lr_done", 32'(done), 32'h1);
        check("lr_busy3", 32'(busy), 32'h0);
        tick(); check("lr_done_once", 32'(done), 32'h0);

        // rotate left 81 by 9
        go(8'h81, 9, 1'b0, 2'b01, 1'b0);
        for (int i = 0; i < 8; i++) tick();
        check("rot_8", 32'(q), 32'h81);
        check("rot_busy8", 32'(busy), 32'h1);
        tick();
        check("rot_9", 32'(q), 32'h03);
        check("rot_so", 32'(ser_out), 32'h1);
        check("rot_done", 32'(done), 32'h1);
        tick();

        // arithmetic right 90 by 2
        go(8'h90, 2, 1'b1, 2'b10, 1'b1);
        tick(); check("ar_s1", 32'(q), 32'hC8);
        tick(); check("ar_s2", 32'(q), 32'hE4);
        check("ar_so", 32'(ser_out), 32'h0);
        tick();

        // zero count, then load in the done cycle
        go(8'h5A, 0, 1'b0, 2'b00, 1'b0);
        check("zc_q", 32'(q), 32'h5A);
        check("zc_busy", 32'(busy), 32'h0);
        check("zc_done", 32'(done), 32'h1);
        load = 1; data = 8'h3C;
        tick();
        check("ld_q", 32'(q), 32'h3C);
        check("ld_so", 32'(ser_out), 32'h0);
        check("ld_done", 32'(done), 32'h0);
        idle_inputs();
        tick();

        // start ignored during SHIFT, then abort
        go(8'h01, 5, 1'b0, 2'b00, 1'b0);
        start = 1; data = 8'hFF; count = CW'(1);
        tick(); check("ab_shift1", 32'(q), 32'h02);
        start = 0; abort = 1;
        tick();
        check("ab_hold", 32'(q), 32'h02);
        check("ab_busy", 32'(busy), 32'h0);
        check("ab_done", 32'(done), 32'h0);
        abort = 0;
        tick(); check("ab_no_done", 32'(done), 32'h0);

        // back-to-back: start accepted during done
        go(8'h0F, 1, 1'b1, 2'b01, 1'b0);
        tick();
        check("bb_q1", 32'(q), 32'h87);
        check("bb_done1", 32'(done), 32'h1);
        go(8'h33, 2, 1'b0, 2'b11, 1'b1);
        check("bb_q2", 32'(q), 32'h33);
        check("bb_busy2", 32'(busy), 32'h1);
        tick(); tick();
        check("bb_end", 32'(q), 32'hCF);
        tick();

        // randomized traffic
        for (int n = 0; n < 600; n++) begin
            idle_inputs();
            data   = WIDTH'($urandom);
            count  = CW'($urandom_range(0, (1 << CW) - 1));
            dir    = 1'($urandom);
            mode   = 2'($urandom);
            ser_in = 1'($urandom);
            start  = ($urandom_range(0, 3) == 0);
            load   = ($urandom_range(0, 4) == 0);
            if (m_phase == 1) abort = ($urandom_range(0, 19) == 0);
            rst    = ($urandom_range(0, 99) == 0);
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
